// File: rtl/multizone_climate_ctrl.sv
// Multi-zone climate controller: shared mode FSM, per-zone debounced setpoint
// buttons, hysteretic target banding, rate-limited fan ramp and vent target.
module multizone_climate_ctrl #(
  parameter int unsigned ZONES    = 2,
  parameter int unsigned TEMP_W   = 7,
  parameter int unsigned MIN_SP   = 18,
  parameter int unsigned MAX_SP   = 26,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned RAMP_DIV = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_mode,
  input  logic [ZONES-1:0]        btn_up,
  input  logic [ZONES-1:0]        btn_down,
  input  logic [ZONES*TEMP_W-1:0] temperature,
  output logic [1:0]              mode,
  output logic [ZONES*TEMP_W-1:0] setpoint,
  output logic [ZONES*3-1:0]      fan_speed,
  output logic [ZONES*8-1:0]      fan_heat,
  output logic [ZONES-1:0]        heating
);

  localparam int unsigned NBTN  = 2 * ZONES + 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);
  localparam int unsigned RC_W  = $clog2(RAMP_DIV + 1);
  localparam int unsigned SUM_W = ((TEMP_W > 8) ? TEMP_W : 8) + 1;

  typedef enum logic [1:0] {
    M_OFF  = 2'b00,
    M_AUTO = 2'b01,
    M_FAST = 2'b10,
    M_ECO  = 2'b11
  } mode_e;

  // Button index map: 0 = mode, 1..ZONES = up, ZONES+1..2*ZONES = down.
  logic [NBTN-1:0]   btn_raw;
  logic [DB_W-1:0]   db_cnt_q [NBTN];
  logic [DB_W-1:0]   db_cnt_d [NBTN];
  logic [NBTN-1:0]   ev_q, ev_d;

  mode_e             mode_q, mode_d;

  logic [TEMP_W-1:0] temp_z  [ZONES];
  logic [TEMP_W-1:0] sp_q    [ZONES];
  logic [TEMP_W-1:0] sp_d    [ZONES];
  logic [TEMP_W-1:0] diff_q  [ZONES];
  logic [TEMP_W-1:0] diff_d  [ZONES];
  logic [ZONES-1:0]  heating_q, heating_d;
  logic [2:0]        tgt_q   [ZONES];
  logic [2:0]        tgt_d   [ZONES];
  logic [2:0]        fan_q   [ZONES];
  logic [2:0]        fan_d   [ZONES];
  logic [RC_W-1:0]   rc_q    [ZONES];
  logic [RC_W-1:0]   rc_d    [ZONES];
  logic [7:0]        heat_q  [ZONES];
  logic [7:0]        heat_d  [ZONES];

  assign btn_raw = {btn_down, btn_up, btn_mode};
  assign mode    = mode_q;
  assign heating = heating_q;

  // Slice the packed sensor/actuator buses per zone.
  for (genvar z = 0; z < ZONES; z++) begin : g_zone_io
    assign temp_z[z]                       = temperature[z*TEMP_W +: TEMP_W];
    assign setpoint[z*TEMP_W +: TEMP_W]    = sp_q[z];
    assign fan_speed[z*3 +: 3]             = fan_q[z];
    assign fan_heat[z*8 +: 8]              = heat_q[z];
  end

  // Nonzero fan band for a given temperature difference.
  function automatic logic [2:0] level_of(input logic [TEMP_W-1:0] d);
    logic [2:0] lvl;
    lvl = 3'd4;
    if (d <= TEMP_W'(4))      lvl = 3'd1;
    else if (d <= TEMP_W'(6)) lvl = 3'd2;
    else if (d <= TEMP_W'(8)) lvl = 3'd3;
    return lvl;
  endfunction

  // Vent target from ramped level; heat direction only applies in AUTO.
  function automatic logic [7:0] heat_of(input mode_e md, input logic [2:0] lvl,
                                         input logic [TEMP_W-1:0] sp, input logic htg);
    logic [SUM_W-1:0] off;
    logic [SUM_W-1:0] sp_x;
    logic [SUM_W-1:0] res;
    sp_x = SUM_W'(sp);
    case (md)
      M_AUTO:  off = SUM_W'({lvl, 1'b0}) - SUM_W'(1);
      M_FAST:  off = SUM_W'(5);
      default: off = SUM_W'(2);
    endcase
    if (md == M_AUTO && htg) res = sp_x + off;
    else if (sp_x >= off)    res = sp_x - off;
    else                     res = '0;
    if (md == M_OFF || lvl == 3'd0) res = '0;
    return (res > SUM_W'(255)) ? 8'd255 : res[7:0];
  endfunction

  // Debounce: count high samples, fire once when the count reaches DEBOUNCE.
  always_comb begin
    ev_d = '0;
    for (int b = 0; b < NBTN; b++) begin
      db_cnt_d[b] = '0;
      if (btn_raw[b]) begin
        db_cnt_d[b] = (db_cnt_q[b] == DB_W'(DEBOUNCE)) ? db_cnt_q[b] : db_cnt_q[b] + DB_W'(1);
        ev_d[b]     = (db_cnt_q[b] == DB_W'(DEBOUNCE - 1));
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NBTN; b++) db_cnt_q[b] <= '0;
      ev_q <= '0;
    end else begin
      for (int b = 0; b < NBTN; b++) db_cnt_q[b] <= db_cnt_d[b];
      ev_q <= ev_d;
    end
  end

  // Mode FSM next state: cycle OFF -> AUTO -> FAST -> ECO on each press.
  always_comb begin
    mode_d = mode_q;
    if (ev_q[0]) begin
      case (mode_q)
        M_OFF:   mode_d = M_AUTO;
        M_AUTO:  mode_d = M_FAST;
        M_FAST:  mode_d = M_ECO;
        M_ECO:   mode_d = M_OFF;
        default: mode_d = M_OFF;
      endcase
    end
  end

  // Mode FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mode_q <= M_OFF;
    else        mode_q <= mode_d;
  end

  // Per-zone setpoint, difference, target band, fan ramp and vent target.
  always_comb begin
    heating_d = '0;
    for (int z = 0; z < ZONES; z++) begin
      sp_d[z]   = sp_q[z];
      tgt_d[z]  = 3'd0;
      fan_d[z]  = fan_q[z];
      rc_d[z]   = '0;

      if (ev_q[1+z] && !ev_q[1+ZONES+z] && (sp_q[z] < TEMP_W'(MAX_SP)))
        sp_d[z] = sp_q[z] + TEMP_W'(1);
      else if (ev_q[1+ZONES+z] && !ev_q[1+z] && (sp_q[z] > TEMP_W'(MIN_SP)))
        sp_d[z] = sp_q[z] - TEMP_W'(1);

      diff_d[z]    = (temp_z[z] >= sp_q[z]) ? temp_z[z] - sp_q[z] : sp_q[z] - temp_z[z];
      heating_d[z] = (temp_z[z] < sp_q[z]);

      case (mode_q)
        M_FAST:  tgt_d[z] = 3'd4;
        M_ECO:   tgt_d[z] = 3'd2;
        M_AUTO: begin
          if (tgt_q[z] == 3'd0)
            tgt_d[z] = (diff_q[z] >= TEMP_W'(3)) ? level_of(diff_q[z]) : 3'd0;
          else
            tgt_d[z] = (diff_q[z] <= TEMP_W'(1)) ? 3'd0 : level_of(diff_q[z]);
        end
        default: tgt_d[z] = 3'd0;
      endcase

      if (mode_q == M_OFF) begin
        fan_d[z] = 3'd0;
      end else if (fan_q[z] != tgt_q[z]) begin
        if (rc_q[z] == RC_W'(RAMP_DIV - 1))
          fan_d[z] = (fan_q[z] < tgt_q[z]) ? fan_q[z] + 3'd1 : fan_q[z] - 3'd1;
        else
          rc_d[z] = rc_q[z] + RC_W'(1);
      end

      heat_d[z] = heat_of(mode_q, fan_q[z], sp_q[z], heating_q[z]);
    end
  end

  // Per-zone state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      heating_q <= '0;
      for (int z = 0; z < ZONES; z++) begin
        sp_q[z]   <= TEMP_W'(MIN_SP);
        diff_q[z] <= '0;
        tgt_q[z]  <= '0;
        fan_q[z]  <= '0;
        rc_q[z]   <= '0;
        heat_q[z] <= '0;
      end
    end else begin
      heating_q <= heating_d;
      for (int z = 0; z < ZONES; z++) begin
        sp_q[z]   <= sp_d[z];
        diff_q[z] <= diff_d[z];
        tgt_q[z]  <= tgt_d[z];
        fan_q[z]  <= fan_d[z];
        rc_q[z]   <= rc_d[z];
        heat_q[z] <= heat_d[z];
      end
    end
  end

endmodule
